// File: rtl/ball_centroid.sv
// Colour-match centroid tracker: accumulates matching-pixel sums per frame and
// divides them sequentially at frame end. Optional bounding box under BALL_BBOX_EN.
module ball_centroid #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int MIN_COUNT = 16,
  parameter int SUM_W     = 32,
  parameter int QW        = 12
) (
  input  logic        clk_100M,
  input  logic        rst_p,
  input  logic        en,
  input  logic        shift_clk_en,
  input  logic [15:0] CrCb,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  input  logic [15:0] color_sample,
  input  logic [7:0]  thresh,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic        ball_found,
  output logic        ball_valid,
  output logic        overrun,
  output logic [11:0] bbox_min_x,
  output logic [11:0] bbox_max_x,
  output logic [11:0] bbox_min_y,
  output logic [11:0] bbox_max_y
);

  localparam int CW  = 17;
  localparam int STW = (QW > 1) ? $clog2(QW) : 1;
  localparam int DW  = SUM_W + QW;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;

  state_t            state_q, state_d;
  logic [STW-1:0]    step_q, step_d;
  logic [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CW-1:0]     count_q, count_d;
  logic              frame_seen_q, frame_seen_d;
  logic              start_q, start_d;
  logic [SUM_W-1:0]  rem_q, rem_d, snap_sy_q, snap_sy_d;
  logic [CW-1:0]     snap_cnt_q, snap_cnt_d;
  logic [QW-1:0]     quo_q, quo_d, qx_q, qx_d;
  logic              ovf_q, ovf_d;
  logic [11:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic              ball_found_q, ball_found_d;
  logic              ball_valid_q, ball_valid_d;
  logic              overrun_q, overrun_d;

  logic              sample, match, frame_start, frame_end, take;
  logic [7:0]        cr_diff, cb_diff;
  logic [DW-1:0]     rem_ext, cnt_ext, trial;
  logic [STW-1:0]    bit_idx;
  logic              cnt_nz, ovf_now;

`ifdef BALL_BBOX_EN
  logic [11:0] bmin_x_q, bmin_x_d, bmax_x_q, bmax_x_d, bmin_y_q, bmin_y_d, bmax_y_q, bmax_y_d;
  logic [11:0] smin_x_q, smin_x_d, smax_x_q, smax_x_d, smin_y_q, smin_y_d, smax_y_q, smax_y_d;
  logic [11:0] obmin_x_q, obmin_x_d, obmax_x_q, obmax_x_d, obmin_y_q, obmin_y_d, obmax_y_q, obmax_y_d;
`endif

  always_comb begin
    sample  = shift_clk_en & en;
    cr_diff = (CrCb[15:8] >= color_sample[15:8]) ? CrCb[15:8] - color_sample[15:8]
                                                 : color_sample[15:8] - CrCb[15:8];
    cb_diff = (CrCb[7:0] >= color_sample[7:0]) ? CrCb[7:0] - color_sample[7:0]
                                               : color_sample[7:0] - CrCb[7:0];
    match       = sample && (cr_diff <= thresh) && (cb_diff <= thresh);
    frame_start = sample && (pixel_x == 12'd0) && (pixel_y == 12'd0);
    frame_end   = sample && (pixel_x == 12'(H_ACTIVE - 1)) && (pixel_y == 12'(V_ACTIVE - 1))
                  && frame_seen_q;
    take        = frame_end && (state_q == ACCUM) && !start_q;
  end

  always_comb begin
    sum_x_d      = sum_x_q;
    sum_y_d      = sum_y_q;
    count_d      = count_q;
    frame_seen_d = frame_seen_q;
`ifdef BALL_BBOX_EN
    bmin_x_d = bmin_x_q;
    bmax_x_d = bmax_x_q;
    bmin_y_d = bmin_y_q;
    bmax_y_d = bmax_y_q;
`endif
    if (frame_start) begin
      sum_x_d      = match ? SUM_W'(pixel_x) : '0;
      sum_y_d      = match ? SUM_W'(pixel_y) : '0;
      count_d      = match ? CW'(1) : '0;
      frame_seen_d = 1'b1;
`ifdef BALL_BBOX_EN
      bmin_x_d = match ? pixel_x : '1;
      bmax_x_d = match ? pixel_x : '0;
      bmin_y_d = match ? pixel_y : '1;
      bmax_y_d = match ? pixel_y : '0;
`endif
    end else if (match) begin
      sum_x_d = sum_x_q + SUM_W'(pixel_x);
      sum_y_d = sum_y_q + SUM_W'(pixel_y);
      count_d = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
`ifdef BALL_BBOX_EN
      if (pixel_x < bmin_x_q) bmin_x_d = pixel_x;
      if (pixel_x > bmax_x_q) bmax_x_d = pixel_x;
      if (pixel_y < bmin_y_q) bmin_y_d = pixel_y;
      if (pixel_y > bmax_y_q) bmax_y_d = pixel_y;
`endif
    end
    if (frame_end) frame_seen_d = 1'b0;
  end

  // Frame end only arms start_q; the FSM leaves ACCUM one cycle later so the
  // divider always begins from registered snapshot values.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    qx_d         = qx_q;
    ovf_d        = ovf_q;
    start_d      = 1'b0;
    snap_sy_d    = snap_sy_q;
    snap_cnt_d   = snap_cnt_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    ball_found_d = ball_found_q;
    ball_valid_d = 1'b0;
    overrun_d    = frame_end && !take;
`ifdef BALL_BBOX_EN
    smin_x_d  = smin_x_q;
    smax_x_d  = smax_x_q;
    smin_y_d  = smin_y_q;
    smax_y_d  = smax_y_q;
    obmin_x_d = obmin_x_q;
    obmax_x_d = obmax_x_q;
    obmin_y_d = obmin_y_q;
    obmax_y_d = obmax_y_q;
`endif
    cnt_nz  = (snap_cnt_q != '0);
    rem_ext = DW'(rem_q);
    cnt_ext = DW'(snap_cnt_q);
    bit_idx = STW'(QW - 1) - step_q;
    trial   = cnt_ext << bit_idx;
    ovf_now = (step_q == '0) ? (cnt_nz && (rem_ext >= (cnt_ext << QW))) : ovf_q;

    if (take) begin
      rem_d      = sum_x_d;
      snap_sy_d  = sum_y_d;
      snap_cnt_d = count_d;
      start_d    = 1'b1;
`ifdef BALL_BBOX_EN
      smin_x_d = bmin_x_d;
      smax_x_d = bmax_x_d;
      smin_y_d = bmin_y_d;
      smax_y_d = bmax_y_d;
`endif
    end

    case (state_q)
      ACCUM: begin
        if (start_q) begin
          state_d = DIV_X;
          step_d  = '0;
          quo_d   = '0;
        end
      end
      DIV_X, DIV_Y: begin
        ovf_d = ovf_now;
        if (cnt_nz && (rem_ext >= trial)) begin
          rem_d          = rem_q - trial[SUM_W-1:0];
          quo_d[bit_idx] = 1'b1;
        end
        if (step_q == STW'(QW - 1)) begin
          step_d = '0;
          if (state_q == DIV_X) begin
            qx_d    = ovf_now ? '1 : quo_d;
            rem_d   = snap_sy_q;
            quo_d   = '0;
            state_d = DIV_Y;
          end else begin
            quo_d   = ovf_now ? '1 : quo_d;
            state_d = PUBLISH;
          end
        end else begin
          step_d = step_q + STW'(1);
        end
      end
      PUBLISH: begin
        ball_valid_d = 1'b1;
        state_d      = ACCUM;
        if (snap_cnt_q >= CW'(MIN_COUNT)) begin
          ball_x_d     = 12'(qx_q);
          ball_y_d     = 12'(quo_q);
          ball_found_d = 1'b1;
`ifdef BALL_BBOX_EN
          obmin_x_d = smin_x_q;
          obmax_x_d = smax_x_q;
          obmin_y_d = smin_y_q;
          obmax_y_d = smax_y_q;
`endif
        end else begin
          ball_found_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      state_q      <= ACCUM;
      step_q       <= '0;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      count_q      <= '0;
      frame_seen_q <= 1'b0;
      start_q      <= 1'b0;
      rem_q        <= '0;
      snap_sy_q    <= '0;
      snap_cnt_q   <= '0;
      quo_q        <= '0;
      qx_q         <= '0;
      ovf_q        <= 1'b0;
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      ball_found_q <= 1'b0;
      ball_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      count_q      <= count_d;
      frame_seen_q <= frame_seen_d;
      start_q      <= start_d;
      rem_q        <= rem_d;
      snap_sy_q    <= snap_sy_d;
      snap_cnt_q   <= snap_cnt_d;
      quo_q        <= quo_d;
      qx_q         <= qx_d;
      ovf_q        <= ovf_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      ball_found_q <= ball_found_d;
      ball_valid_q <= ball_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef BALL_BBOX_EN
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      bmin_x_q  <= '0;
      bmax_x_q  <= '0;
      bmin_y_q  <= '0;
      bmax_y_q  <= '0;
      smin_x_q  <= '0;
      smax_x_q  <= '0;
      smin_y_q  <= '0;
      smax_y_q  <= '0;
      obmin_x_q <= '0;
      obmax_x_q <= '0;
      obmin_y_q <= '0;
      obmax_y_q <= '0;
    end else begin
      bmin_x_q  <= bmin_x_d;
      bmax_x_q  <= bmax_x_d;
      bmin_y_q  <= bmin_y_d;
      bmax_y_q  <= bmax_y_d;
      smin_x_q  <= smin_x_d;
      smax_x_q  <= smax_x_d;
      smin_y_q  <= smin_y_d;
      smax_y_q  <= smax_y_d;
      obmin_x_q <= obmin_x_d;
      obmax_x_q <= obmax_x_d;
      obmin_y_q <= obmin_y_d;
      obmax_y_q <= obmax_y_d;
    end
  end

  assign bbox_min_x = obmin_x_q;
  assign bbox_max_x = obmax_x_q;
  assign bbox_min_y = obmin_y_q;
  assign bbox_max_y = obmax_y_q;
`else
  assign bbox_min_x = '0;
  assign bbox_max_x = '0;
  assign bbox_min_y = '0;
  assign bbox_max_y = '0;
`endif

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign ball_found = ball_found_q;
  assign ball_valid = ball_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ball_centroid.sv
// Randomized bench for ball_centroid: frames are sparse pixel lists scored by an
// arithmetic reference model (sums, counts, integer division, min/max).
module tb_ball_centroid;

  logic        clk_100M = 1'b0;
  logic        rst_p;
  logic        en;
  logic        shift_clk_en;
  logic [15:0] CrCb;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic [15:0] color_sample;
  logic [7:0]  thresh;
  logic [11:0] ball_x, ball_y;
  logic        ball_found, ball_valid, overrun;
  logic [11:0] bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;

  always #5 clk_100M = ~clk_100M;

  ball_centroid #(.H_ACTIVE(320), .V_ACTIVE(240), .MIN_COUNT(16), .SUM_W(32), .QW(12)) dut (
    .clk_100M(clk_100M), .rst_p(rst_p), .en(en), .shift_clk_en(shift_clk_en),
    .CrCb(CrCb), .pixel_x(pixel_x), .pixel_y(pixel_y), .color_sample(color_sample),
    .thresh(thresh), .ball_x(ball_x), .ball_y(ball_y), .ball_found(ball_found),
    .ball_valid(ball_valid), .overrun(overrun), .bbox_min_x(bbox_min_x),
    .bbox_max_x(bbox_max_x), .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y)
  );

  typedef struct {
    logic        e;
    logic        s;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] c;
  } pix_t;

  pix_t fq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_x = 0, exp_y = 0, exp_found = 0;
  int   exp_bb[4] = '{0, 0, 0, 0};
  int   lat, n_valid, n_ovr;
  logic [11:0] cap_x, cap_y;
  logic        cap_found;
  logic [11:0] cap_bb[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit is_match(input logic [15:0] c, input logic [15:0] r, input int t);
    return adiff(int'(c[15:8]), int'(r[15:8])) <= t && adiff(int'(c[7:0]), int'(r[7:0])) <= t;
  endfunction

  task automatic push(input logic e, input logic s, input int x, input int y, input logic [15:0] c);
    pix_t p;
    p.e = e; p.s = s; p.x = 12'(x); p.y = 12'(y); p.c = c;
    fq.push_back(p);
  endtask

  task automatic send_queue();
    foreach (fq[i]) begin
      @(negedge clk_100M);
      en = fq[i].e; shift_clk_en = fq[i].s;
      pixel_x = fq[i].x; pixel_y = fq[i].y; CrCb = fq[i].c;
    end
  endtask

  // Fixed 40-cycle window after the frame-end edge; optional reset and an
  // injected second frame (start/end) to provoke an overrun.
  task automatic wait_result(input int rst_at, input int ostart, input int oend);
    lat = -1; n_valid = 0; n_ovr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_100M);
      rst_p = (rst_at != 0) && (k == rst_at);
      shift_clk_en = 1'b0;
      if (k == ostart) begin
        en = 1'b1; shift_clk_en = 1'b1; pixel_x = 12'd0; pixel_y = 12'd0;
        CrCb = color_sample ^ 16'h8080;
      end
      if (k == oend) begin
        en = 1'b1; shift_clk_en = 1'b1; pixel_x = 12'd319; pixel_y = 12'd239;
        CrCb = color_sample ^ 16'h8080;
      end
      @(posedge clk_100M);
      #1;
      if (ball_valid) begin
        n_valid++;
        if (lat < 0) begin
          lat = k; cap_x = ball_x; cap_y = ball_y; cap_found = ball_found;
          cap_bb[0] = bbox_min_x; cap_bb[1] = bbox_max_x;
          cap_bb[2] = bbox_min_y; cap_bb[3] = bbox_max_y;
        end
      end
      if (overrun) n_ovr++;
    end
  endtask

  task automatic do_frame(input string tag, input int rst_at, input int ostart, input int oend);
    int cnt = 0, mnx = 4095, mxx = 0, mny = 4095, mxy = 0;
    longint sx = 0, sy = 0;
    foreach (fq[i]) begin
      if (fq[i].e && fq[i].s && is_match(fq[i].c, color_sample, int'(thresh))) begin
        cnt++; sx += fq[i].x; sy += fq[i].y;
        if (fq[i].x < mnx) mnx = fq[i].x;
        if (fq[i].x > mxx) mxx = fq[i].x;
        if (fq[i].y < mny) mny = fq[i].y;
        if (fq[i].y > mxy) mxy = fq[i].y;
      end
    end
    send_queue();
    wait_result(rst_at, ostart, oend);
    if (rst_at != 0) begin
      check({tag, "_rst_valid"}, n_valid, 0);
      check({tag, "_rst_x"}, ball_x, 0);
      check({tag, "_rst_found"}, ball_found, 0);
      exp_x = 0; exp_y = 0; exp_found = 0; exp_bb = '{0, 0, 0, 0};
    end else begin
      exp_found = (cnt >= 16);
      if (exp_found != 0) begin
        exp_x = (sx / cnt > 4095) ? 4095 : int'(sx / cnt);
        exp_y = (sy / cnt > 4095) ? 4095 : int'(sy / cnt);
`ifdef BALL_BBOX_EN
        exp_bb = '{mnx, mxx, mny, mxy};
`endif
      end
      check({tag, "_latency"}, lat, 26);
      check({tag, "_npulse"}, n_valid, 1);
      check({tag, "_found"}, cap_found, exp_found);
      check({tag, "_x"}, cap_x, exp_x);
      check({tag, "_y"}, cap_y, exp_y);
      for (int b = 0; b < 4; b++) check({tag, "_bbox"}, cap_bb[b], exp_bb[b]);
      check({tag, "_overrun"}, n_ovr, (oend != 0) ? 1 : 0);
    end
    fq.delete();
  endtask

  function automatic logic [15:0] rand_col(input logic [15:0] r, input int t);
    int cr, cb;
    if ($urandom_range(0, 99) < 65) begin
      cr = int'(r[15:8]) + int'($urandom_range(0, 2 * t + 4)) - (t + 2);
      cb = int'(r[7:0]) + int'($urandom_range(0, 2 * t + 4)) - (t + 2);
      cr = (cr < 0) ? 0 : (cr > 255) ? 255 : cr;
      cb = (cb < 0) ? 0 : (cb > 255) ? 255 : cb;
      return {8'(cr), 8'(cb)};
    end
    return 16'($urandom);
  endfunction

  task automatic gen_block(input int x0, input int y0);
    push(1, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 16; i++) push(1, 1, x0 + i % 4, y0 + i / 4, color_sample);
    for (int i = 0; i < 5; i++) push(1, 1, 150 + i, 200, 16'hFFFF);
    push(1, 1, 319, 239, 16'h0000);
  endtask

  initial begin
    rst_p = 1'b1; en = 1'b0; shift_clk_en = 1'b0; CrCb = '0;
    pixel_x = '0; pixel_y = '0; color_sample = 16'h8040; thresh = 8'd10;
    repeat (3) @(posedge clk_100M);
    #1;
    check("reset_x", ball_x, 0);
    check("reset_y", ball_y, 0);
    check("reset_found", ball_found, 0);
    check("reset_valid", ball_valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_bbox", {bbox_min_x, bbox_max_x}, 0);
    @(negedge clk_100M);
    rst_p = 1'b0;

    // frame end without a preceding frame start is ignored
    push(1, 1, 319, 239, color_sample);
    send_queue();
    fq.delete();
    wait_result(0, 0, 0);
    check("orphan_end_valid", n_valid, 0);

    push(1, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 20; i++) push(1, 1, 5 + i, 7, 16'hFFFF);
    push(1, 1, 319, 239, 16'h0000);
    do_frame("nomatch", 0, 0, 0);
    check("nomatch_x_const", ball_x, 0);

    gen_block(100, 50);
    do_frame("block", 0, 0, 0);
    check("block_x_const", ball_x, 101);
    check("block_y_const", ball_y, 51);
    check("block_found_const", ball_found, 1);
`ifdef BALL_BBOX_EN
    check("block_bbox_const", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y},
          {12'd100, 12'd103, 12'd50, 12'd53});
`else
    check("block_bbox_const", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}, 0);
`endif

    // diff exactly thresh matches, diff thresh+1 rejects: 15 matches only
    push(1, 1, 0, 0, {8'd138, 8'd64});
    for (int i = 0; i < 14; i++) begin
      case (i % 4)
        0: push(1, 1, 200 + i, 100, {8'd118, 8'd64});
        1: push(1, 1, 200 + i, 100, {8'd128, 8'd74});
        2: push(1, 1, 200 + i, 100, {8'd128, 8'd54});
        default: push(1, 1, 200 + i, 100, {8'd138, 8'd74});
      endcase
    end
    push(1, 1, 210, 101, {8'd139, 8'd64});
    push(1, 1, 211, 101, {8'd128, 8'd75});
    push(1, 1, 319, 239, 16'h0000);
    do_frame("thresh", 0, 0, 0);
    check("thresh_found_const", ball_found, 0);
    check("thresh_x_const", ball_x, 101);
    check("thresh_y_const", ball_y, 51);

    gen_block(10, 20);
    do_frame("overrun", 0, 3, 5);

    gen_block(30, 40);
    do_frame("midreset", 16, 0, 0);

    gen_block(100, 50);
    do_frame("after_reset", 0, 0, 0);
    check("after_reset_x_const", ball_x, 101);

    for (int f = 0; f < 12; f++) begin
      int n, t;
      color_sample = 16'($urandom);
      t = int'($urandom_range(0, 40));
      thresh = 8'(t);
      push(1, 1, 0, 0, rand_col(color_sample, t));
      n = int'($urandom_range(8, 50));
      for (int i = 0; i < n; i++)
        push($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
             int'($urandom_range(1, 318)), int'($urandom_range(0, 238)),
             rand_col(color_sample, t));
      push(1, 1, 319, 239, rand_col(color_sample, t));
      do_frame("random", 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
